// File: rtl/rv64_wb_scheduler_pkg.sv
// Shared constants, source encoding and helpers for the GPR writeback scheduler.
// These constants size the regfile write port and the writeback requesters.
package rv64_wb_scheduler_pkg;

    localparam int unsigned RV_XLEN          = 32'd64;
    localparam int unsigned RV_REG_ADDRWIDTH = 32'd5;
    localparam int unsigned RV_REG_NUM       = 32'd32;
    localparam int unsigned RV_NREQ          = 32'd3;

    // Requester slot numbering on the packed request buses.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_MDU = 2'd2
    } wb_src_e;

    // Folds an index that may have passed n back into the range 0..n-1.
    // This is enough because the callers never add more than n-1.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/rv64_wb_scheduler_rr_arbiter.sv
// Generic one-hot round-robin arbiter with a registered priority pointer.
// The grant is combinational from valid and the pointer, and it is forced low while rst is low.
module rv_rr_arbiter
    import rv64_wb_scheduler_pkg::*;
#(
    parameter int unsigned N  = RV_NREQ,
    parameter int unsigned IW = (N > 32'd1) ? $clog2(N) : 32'd1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  valid,
    output logic [N-1:0]  grant,
    output logic          grant_any,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] rr_r;
    logic [N-1:0]  grant_s;
    logic [IW-1:0] grant_idx_s;
    logic          found_s;
    logic          hit_s;

    // The search starts at rr_r and moves up modulo N. The first valid requester wins.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        found_s     = 1'b0;
        hit_s       = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                hit_s       = !found_s && valid[j] && (rr_wrap(32'(rr_r) + k, N) == j);
                grant_s[j]  = grant_s[j] | hit_s;
                grant_idx_s = hit_s ? IW'(j) : grant_idx_s;
                found_s     = found_s | hit_s;
            end
        end
    end

    assign grant     = grant_s & {N{rst}};
    assign grant_any = found_s & rst;
    assign grant_idx = grant_idx_s;

    // After a grant the pointer moves to the slot just past the winner.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_r <= '0;
        end else if (grant_any) begin
            rr_r <= (grant_idx_s == IW'(N - 32'd1)) ? '0 : (grant_idx_s + IW'(1));
        end else begin
            rr_r <= rr_r;
        end
    end

endmodule

// File: rtl/rv64_wb_scheduler.sv
// This block gives the single GPR write port to one writeback source per cycle and registers that write.
// It also keeps the pending-write scoreboard that decode uses for RAW and WAW stall checks.
module rv64_wb_scheduler
    import rv64_wb_scheduler_pkg::*;
#(
    parameter int unsigned XLEN          = RV_XLEN,
    parameter int unsigned REG_ADDRWIDTH = RV_REG_ADDRWIDTH,
    parameter int unsigned REG_NUM       = RV_REG_NUM,
    parameter int unsigned NREQ          = RV_NREQ
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req_valid_i,
    output logic [NREQ-1:0]                 req_ready_o,
    input  logic [NREQ*REG_ADDRWIDTH-1:0]   req_idx_i,
    input  logic [NREQ*XLEN-1:0]            req_data_i,
    output logic [REG_ADDRWIDTH-1:0]        write_idx_o,
    output logic [XLEN-1:0]                 write_data_o,
    output logic                            write_data_valid_o,
    input  logic                            issue_valid_i,
    input  logic [REG_ADDRWIDTH-1:0]        issue_rd_i,
    input  logic [REG_ADDRWIDTH-1:0]        chk_rs1_i,
    input  logic [REG_ADDRWIDTH-1:0]        chk_rs2_i,
    input  logic [REG_ADDRWIDTH-1:0]        chk_rd_i,
    output logic                            hazard_o,
    output logic [REG_NUM-1:0]              busy_o
);

    localparam int unsigned IW = (NREQ > 32'd1) ? $clog2(NREQ) : 32'd1;

    logic [NREQ-1:0]          grant_s;
    logic                     grant_any_s;
    logic [IW-1:0]            grant_idx_s;
    logic [REG_ADDRWIDTH-1:0] sel_idx_s;
    logic [XLEN-1:0]          sel_data_s;
    logic [REG_ADDRWIDTH-1:0] write_idx_r;
    logic [XLEN-1:0]          write_data_r;
    logic                     write_valid_r;
    logic [REG_NUM-1:0]       busy_r;
    logic [REG_NUM-1:0]       busy_next_s;
    logic [REG_NUM-1:0]       set_s;
    logic [REG_NUM-1:0]       clr_s;

    rv_rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (req_valid_i),
        .grant     (grant_s),
        .grant_any (grant_any_s),
        .grant_idx (grant_idx_s)
    );

    assign req_ready_o = grant_s;

    // Select the index and data slices of the granted requester.
    always_comb begin
        sel_idx_s  = '0;
        sel_data_s = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            sel_idx_s  = (grant_idx_s == IW'(j)) ? req_idx_i[j*REG_ADDRWIDTH +: REG_ADDRWIDTH] : sel_idx_s;
            sel_data_s = (grant_idx_s == IW'(j)) ? req_data_i[j*XLEN +: XLEN] : sel_data_s;
        end
    end

    // Write port register. An x0 write uses the port for a cycle but never raises valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_idx_r   <= '0;
            write_data_r  <= '0;
            write_valid_r <= 1'b0;
        end else if (grant_any_s) begin
            write_idx_r   <= sel_idx_s;
            write_data_r  <= sel_data_s;
            write_valid_r <= (sel_idx_s != '0);
        end else begin
            write_valid_r <= 1'b0;
        end
    end

    assign write_idx_o        = write_idx_r;
    assign write_data_o       = write_data_r;
    assign write_data_valid_o = write_valid_r;

    // Scoreboard update. If a register is issued and written on the same edge, the new issue keeps it busy.
    always_comb begin
        set_s = '0;
        clr_s = '0;
        for (int unsigned r = 1; r < REG_NUM; r++) begin
            set_s[r] = issue_valid_i && (issue_rd_i == REG_ADDRWIDTH'(r));
            clr_s[r] = grant_any_s && (sel_idx_s == REG_ADDRWIDTH'(r));
        end
        busy_next_s = (set_s | (busy_r & ~clr_s)) & {{(REG_NUM-1){1'b1}}, 1'b0};
    end

    // Scoreboard state. x0 is never marked busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // The hazard check reads only the registered mask. A clear on the current edge does not count yet.
    assign hazard_o = busy_r[chk_rs1_i] | busy_r[chk_rs2_i] | busy_r[chk_rd_i];
    assign busy_o   = busy_r;

endmodule

// File: tb/tb_rv64_wb_scheduler.sv
// Directed self-checking bench for rv64_wb_scheduler. All expected values are worked out by hand.
module tb_rv64_wb_scheduler;
    import rv64_wb_scheduler_pkg::*;

    logic          clk;
    logic          rst;
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic [14:0]   req_idx;
    logic [191:0]  req_data;
    logic [4:0]    write_idx;
    logic [63:0]   write_data;
    logic          write_valid;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [4:0]    chk_rs1;
    logic [4:0]    chk_rs2;
    logic [4:0]    chk_rd;
    logic          hazard;
    logic [31:0]   busy;

    int checks = 0;
    int errors = 0;

    rv64_wb_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_idx_i          (req_idx),
        .req_data_i         (req_data),
        .write_idx_o        (write_idx),
        .write_data_o       (write_data),
        .write_data_valid_o (write_valid),
        .issue_valid_i      (issue_valid),
        .issue_rd_i         (issue_rd),
        .chk_rs1_i          (chk_rs1),
        .chk_rs2_i          (chk_rs2),
        .chk_rd_i           (chk_rd),
        .hazard_o           (hazard),
        .busy_o             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] exp_g [4];
        logic [4:0] exp_i [4];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_i = '{5'd1, 5'd2, 5'd3, 5'd1};

        // Reset is held for 3 cycles while every requester is asking.
        rst = 1'b0; req_valid = 3'b111; req_idx = 15'd0; req_data = 192'd0;
        issue_valid = 1'b0; issue_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_valid", 64'(write_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
        end

        // Only the LSU requests. Its register was never issued, so the scoreboard stays empty.
        rst = 1'b1; req_valid = 3'b010;
        req_idx[5 +: 5] = 5'd5; req_data[64 +: 64] = 64'h0000_0000_DEAD_BEEF;
        #1;
        chk("lsu_ready", 64'(req_ready), 64'b010);
        tick();
        chk("lsu_idx", 64'(write_idx), 64'd5);
        chk("lsu_data", write_data, 64'h0000_0000_DEAD_BEEF);
        chk("lsu_valid", 64'(write_valid), 64'd1);
        chk("lsu_busy5", 64'(busy[5]), 64'd0);

        // Only the MDU requests. The pointer was at 2, so this grant wraps it back to 0.
        req_idx = {5'd3, 5'd2, 5'd1};
        req_data = {64'd33, 64'd22, 64'd11};
        req_valid = 3'b100;
        #1;
        chk("mdu_ready", 64'(req_ready), 64'b100);
        tick();
        chk("mdu_idx", 64'(write_idx), 64'd3);

        // All three request together for 4 cycles.
        req_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("rr_grant%0d", c), 64'(req_ready), 64'(exp_g[c]));
            tick();
            chk($sformatf("rr_idx%0d", c), 64'(write_idx), 64'(exp_i[c]));
        end

        // An MDU-only grant moves the pointer from 1 to 0. Then the ALU writes x0.
        req_valid = 3'b100;
        tick();
        req_idx[0 +: 5] = 5'd0; req_data[0 +: 64] = 64'd7; req_valid = 3'b001;
        #1;
        chk("x0_ready", 64'(req_ready), 64'b001);
        tick();
        chk("x0_valid", 64'(write_valid), 64'd0);
        chk("x0_idx", 64'(write_idx), 64'd0);
        req_valid = 3'b111;
        #1;
        chk("x0_next_lsu", 64'(req_ready), 64'b010);
        req_valid = 3'b000;

        // Issuing to x0 must not mark anything busy.
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        chk("issue_x0_busy", 64'(busy), 64'd0);

        // Part a: x7 is issued, and reads of rs1=x7 stall until the cycle after its write.
        issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0; chk_rs1 = 5'd7;
        #1;
        chk("haz_rs1", 64'(hazard), 64'd1);
        chk("busy7_set", 64'(busy), 64'h80);
        chk_rs1 = 5'd0; chk_rd = 5'd7;
        #1;
        chk("haz_rd", 64'(hazard), 64'd1);
        chk_rd = 5'd0; chk_rs1 = 5'd7;
        tick();
        chk("haz_hold", 64'(hazard), 64'd1);
        req_idx[5 +: 5] = 5'd7; req_data[64 +: 64] = 64'h1234; req_valid = 3'b010;
        #1;
        chk("haz_grant_cycle", 64'(hazard), 64'd1);
        tick();
        req_valid = 3'b000;
        chk("haz_cleared", 64'(hazard), 64'd0);
        chk("busy7_clr", 64'(busy), 64'd0);
        chk("w7_valid", 64'(write_valid), 64'd1);
        chk("w7_idx", 64'(write_idx), 64'd7);

        // Part b: x7 is issued again on the same edge that x7 is written, so it stays busy.
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        req_valid = 3'b010;
        tick();
        issue_valid = 1'b0;
        chk("set_wins_busy", 64'(busy), 64'h80);
        chk("set_wins_valid", 64'(write_valid), 64'd1);
        tick();
        req_valid = 3'b000;
        chk("late_clr_busy", 64'(busy), 64'd0);

        // Reset in the middle of operation, with busy = 0xF0 and requests still pending.
        chk_rs1 = 5'd0; chk_rs2 = 5'd5;
        issue_valid = 1'b1;
        for (int r = 4; r < 8; r++) begin
            issue_rd = 5'(r);
            tick();
        end
        issue_valid = 1'b0;
        chk("busy_f0", 64'(busy), 64'hF0);
        chk("haz_rs2", 64'(hazard), 64'd1);
        req_valid = 3'b111; rst = 1'b0;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'd0);
        tick();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(write_valid), 64'd0);
        chk("midrst_haz", 64'(hazard), 64'd0);
        rst = 1'b1;
        #1;
        chk("midrst_rr0", 64'(req_ready), 64'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
